fixed_mul_pipe: RTL and testbench

//  Parametrised, pipelined signed fixed-point multiply / dequantize unit for the FM radio datapath.

---
 rtl/fixed_pkg.sv | 28 ++
 rtl/fixed_round_sat.sv | 51 +++++
 rtl/fixed_mul_pipe.sv | 148 ++++++++++++++
 tb/tb_fixed_mul_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Package fixed_pkg: shared fixed-point types and defaults for the FM radio datapath.
// Default format is Q22.10 in a 32-bit word, shared with the FIR and demod blocks.
package fixed_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 10;

  // Operation selector carried alongside each sample.
  typedef enum logic {
    OP_MUL = 1'b0,  // (a * b) >> FRAC_BITS
    OP_DEQ = 1'b1   // a >> FRAC_BITS, b ignored
  } op_t;

  // Integer value to default fixed-point format (no range check).
  function automatic logic signed [DEF_DATA_WIDTH-1:0] to_fixed(
    input logic signed [DEF_DATA_WIDTH-1:0] int_val
  );
    return int_val <<< DEF_FRAC_BITS;
  endfunction

  // Default fixed-point format to integer, truncating toward -inf.
  function automatic logic signed [DEF_DATA_WIDTH-1:0] from_fixed(
    input logic signed [DEF_DATA_WIDTH-1:0] fix_val
  );
    return fix_val >>> DEF_FRAC_BITS;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// fixed_round_sat: combinational round / arithmetic shift / range check / clamp-or-wrap
// for a 2*DATA_WIDTH signed product. Also used by the FIR accumulator.
// Build option: FIXED_MUL_SATURATE_EN clamps out-of-range results; otherwise they wrap.
module fixed_round_sat #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int RND_MODE   = 0
) (
  input  logic signed [2*DATA_WIDTH-1:0] prod,
  output logic        [DATA_WIDTH-1:0]   data,
  output logic                           ovf
);

  // One guard bit above the product so the rounding add can never wrap.
  localparam int PW = 2*DATA_WIDTH + 1;

  localparam logic [PW-1:0] RND_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] RND_ADD = (RND_MODE == 1) ? (RND_ONE << (FRAC_BITS-1))
                                                      : {PW{1'b0}};

  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // A value fits in DATA_WIDTH signed bits when every bit from the result
  // sign bit upward is a copy of that sign bit.
  function automatic logic out_of_range(input logic [DATA_WIDTH+1:0] upper_bits);
    return !((&upper_bits) || !(|upper_bits));
  endfunction

  logic signed [PW-1:0]         summed;
  logic signed [PW-1:0]         shifted;
  logic        [DATA_WIDTH+1:0] upper;

  // Round, shift down to the result scale, then range-check and clamp/wrap.
  always_comb begin
    summed  = $signed({prod[2*DATA_WIDTH-1], prod}) + $signed(RND_ADD);
    shifted = summed >>> FRAC_BITS;
    upper   = shifted[PW-1:DATA_WIDTH-1];
    ovf     = out_of_range(upper);
`ifdef FIXED_MUL_SATURATE_EN
    if (ovf) begin
      data = shifted[PW-1] ? MAX_NEG : MAX_POS;
    end else begin
      data = shifted[DATA_WIDTH-1:0];
    end
`else
    data = shifted[DATA_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/fixed_mul_pipe.sv
// fixed_mul_pipe: 3-stage signed fixed-point multiply / dequantize with valid/ready
// handshake on both sides. One sample per cycle; the whole pipe freezes while the
// output holds a sample that downstream has not taken.
// Build option: FIXED_MUL_SATURATE_EN (clamp instead of wrap on overflow, see fixed_round_sat).
module fixed_mul_pipe
  import fixed_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int RND_MODE   = 0,
  parameter int CHAN_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  op_t                   in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [CHAN_BITS-1:0]  in_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CHAN_BITS-1:0]  out_chan,
  output logic                  out_ovf
);

  localparam int PW = 2*DATA_WIDTH;

  logic stall;

  // Stage 1: captured operands
  logic                  s1_valid_q, s1_valid_d;
  op_t                   s1_op_q,    s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [CHAN_BITS-1:0]  s1_chan_q,  s1_chan_d;

  // Stage 2: full-width product
  logic                  s2_valid_q, s2_valid_d;
  logic [PW-1:0]         s2_prod_q,  s2_prod_d;
  logic [CHAN_BITS-1:0]  s2_chan_q,  s2_chan_d;

  // Stage 3: registered outputs
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHAN_BITS-1:0]  out_chan_q,  out_chan_d;
  logic                  out_ovf_q,   out_ovf_d;

  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         b_ext;
  logic [PW-1:0]         prod_s;
  logic [DATA_WIDTH-1:0] rs_data;
  logic                  rs_ovf;

  // Only an undelivered output sample can block the pipe; empty stages never do.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Sign-extended operands and product (OP_DEQ passes a through at product scale).
  always_comb begin
    a_ext = {{DATA_WIDTH{s1_a_q[DATA_WIDTH-1]}}, s1_a_q};
    b_ext = {{DATA_WIDTH{s1_b_q[DATA_WIDTH-1]}}, s1_b_q};
    case (s1_op_q)
      OP_MUL:  prod_s = a_ext * b_ext;
      OP_DEQ:  prod_s = a_ext;
      default: prod_s = a_ext;
    endcase
  end

  fixed_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .RND_MODE   (RND_MODE)
  ) u_round_sat (
    .prod (s2_prod_q),
    .data (rs_data),
    .ovf  (rs_ovf)
  );

  // Next-state: every stage advances together unless stalled, in which case all hold.
  always_comb begin
    if (!stall) begin
      s1_valid_d  = in_valid;
      s1_op_d     = in_op;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_chan_d   = in_chan;
      s2_valid_d  = s1_valid_q;
      s2_prod_d   = prod_s;
      s2_chan_d   = s1_chan_q;
      out_valid_d = s2_valid_q;
      out_data_d  = rs_data;
      out_chan_d  = s2_chan_q;
      out_ovf_d   = rs_ovf;
    end else begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_chan_d   = s1_chan_q;
      s2_valid_d  = s2_valid_q;
      s2_prod_d   = s2_prod_q;
      s2_chan_d   = s2_chan_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_ovf_d   = out_ovf_q;
    end
  end

  // Pipeline registers; reset discards any sample in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_MUL;
      s1_a_q      <= {DATA_WIDTH{1'b0}};
      s1_b_q      <= {DATA_WIDTH{1'b0}};
      s1_chan_q   <= {CHAN_BITS{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= {PW{1'b0}};
      s2_chan_q   <= {CHAN_BITS{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_chan_q  <= {CHAN_BITS{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_chan_q   <= s1_chan_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_chan_q   <= s2_chan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Directed bench for fixed_mul_pipe (W=32, F=10). Two instances share the inputs:
// dut0 uses floor rounding, dut1 round-half-up.
module tb_fixed_mul_pipe;
  import fixed_pkg::*;

  localparam int W = 32;
  localparam int F = 10;
  localparam int C = 1;

`ifdef FIXED_MUL_SATURATE_EN
  localparam logic [W-1:0] EXP_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [W-1:0] EXP_NEG_OVF = 32'h8000_0000;
`else
  localparam logic [W-1:0] EXP_POS_OVF = 32'hFFFF_FFFE;
  localparam logic [W-1:0] EXP_NEG_OVF = 32'h0000_0000;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         out_ready;
  op_t          in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [C-1:0] in_chan;

  logic         in_ready0, out_valid0, out_ovf0;
  logic [W-1:0] out_data0;
  logic [C-1:0] out_chan0;
  logic         in_ready1, out_valid1, out_ovf1;
  logic [W-1:0] out_data1;
  logic [C-1:0] out_chan1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fixed_mul_pipe #(.DATA_WIDTH(W), .FRAC_BITS(F), .RND_MODE(0), .CHAN_BITS(C)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_chan(in_chan),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_chan(out_chan0), .out_ovf(out_ovf0)
  );

  fixed_mul_pipe #(.DATA_WIDTH(W), .FRAC_BITS(F), .RND_MODE(1), .CHAN_BITS(C)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_chan(in_chan),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_chan(out_chan1), .out_ovf(out_ovf1)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [C-1:0] ch);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_chan  = ch;
  endtask

  // Single sample from an empty pipe: checks 3-cycle latency, both rounding modes, ovf, tag.
  task automatic run_one(input string tag, input op_t op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [C-1:0] ch,
                         input logic [W-1:0] e0, input logic [W-1:0] e1, input logic eovf);
    drive(op, a, b, ch);
    @(negedge clock);
    in_valid = 1'b0;
    chk1({tag, "_lat1"}, out_valid0, 1'b0);
    @(negedge clock);
    chk1({tag, "_lat2"}, out_valid0, 1'b0);
    @(negedge clock);
    chk1({tag, "_valid0"}, out_valid0, 1'b1);
    chk1({tag, "_valid1"}, out_valid1, 1'b1);
    chk ({tag, "_data0"},  out_data0,  e0);
    chk ({tag, "_data1"},  out_data1,  e1);
    chk1({tag, "_ovf0"},   out_ovf0,   eovf);
    chk1({tag, "_ovf1"},   out_ovf1,   eovf);
    chk1({tag, "_chan0"},  out_chan0[0], ch[0]);
    chk1({tag, "_chan1"},  out_chan1[0], ch[0]);
    @(negedge clock);
    chk1({tag, "_drain"}, out_valid0, 1'b0);
  endtask

  initial begin
    int idx;
    int ocount;
    int stall_cnt;
    logic accept;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_MUL;
    in_a      = 32'h0;
    in_b      = 32'h0;
    in_chan   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clock);
    chk1("rst_valid", out_valid0, 1'b0);
    chk ("rst_data",  out_data0,  32'h0);
    chk1("rst_chan",  out_chan0[0], 1'b0);
    chk1("rst_ovf",   out_ovf0,   1'b0);
    chk1("rst_ready", in_ready0,  1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk1("post_rst_ready", in_ready0, 1'b1);

    // Basic multiply and dequantize
    run_one("mul_pos",  OP_MUL, 32'h0000_0600, 32'h0000_0800, 1'b1, 32'h0000_0C00, 32'h0000_0C00, 1'b0);
    run_one("mul_neg",  OP_MUL, 32'hFFFF_FA00, 32'h0000_0800, 1'b0, 32'hFFFF_F400, 32'hFFFF_F400, 1'b0);
    run_one("deq",      OP_DEQ, 32'h0000_1C00, 32'hDEAD_BEEF, 1'b1, 32'h0000_0007, 32'h0000_0007, 1'b0);
    // Rounding: +0.5 LSB and -0.5 LSB
    run_one("rnd_pos",  OP_MUL, 32'h0000_0001, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_one("rnd_neg",  OP_MUL, 32'hFFFF_FFFF, 32'h0000_0200, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    // Overflow both directions; largest dequantize stays in range
    run_one("ovf_pos",  OP_MUL, 32'h7FFF_FFFF, 32'h0000_0800, 1'b0, EXP_POS_OVF, EXP_POS_OVF, 1'b1);
    run_one("ovf_neg",  OP_MUL, 32'h8000_0000, 32'h0000_0800, 1'b1, EXP_NEG_OVF, EXP_NEG_OVF, 1'b1);
    run_one("deq_max",  OP_DEQ, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h001F_FFFF, 32'h0020_0000, 1'b0);

    // Backpressure: six samples offered back-to-back, downstream blocked in cycles 4..8
    idx       = 0;
    ocount    = 0;
    stall_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      out_ready = !(t >= 4 && t <= 8);
      if (idx < 6) begin
        drive(OP_MUL, to_fixed(32'(idx + 1)), 32'h0000_0800, 1'(idx));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid0 && !out_ready) begin
        stall_cnt++;
        chk1("bp_ready_low", in_ready0, 1'b0);
        chk ("bp_hold_data", out_data0, to_fixed(32'(2 * (ocount + 1))));
        chk1("bp_hold_chan", out_chan0[0], 1'(ocount));
      end else begin
        chk1("bp_ready_high", in_ready0, 1'b1);
      end
      if (out_valid0 && out_ready) begin
        chk ("bp_data0", out_data0, to_fixed(32'(2 * (ocount + 1))));
        chk ("bp_data1", out_data1, to_fixed(32'(2 * (ocount + 1))));
        chk1("bp_chan",  out_chan0[0], 1'(ocount));
        ocount++;
      end
      accept = in_valid && in_ready0;
      @(negedge clock);
      if (accept) idx++;
      if (ocount == 6) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count",  32'(ocount),    32'd6);
    chk("bp_stalls", 32'(stall_cnt), 32'd5);
    @(negedge clock);
    chk1("bp_drained", out_valid0, 1'b0);

    // Reset with samples in flight
    drive(OP_MUL, 32'h0000_0400, 32'h0000_1400, 1'b1);
    @(negedge clock);
    drive(OP_MUL, 32'h0000_0800, 32'h0000_1400, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk1("mid_valid_before", out_valid0, 1'b1);
    chk ("mid_data_before",  out_data0,  32'h0000_1400);
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_valid0", out_valid0, 1'b0);
    chk1("mid_rst_valid1", out_valid1, 1'b0);
    chk ("mid_rst_data",   out_data0,  32'h0);
    chk1("mid_rst_ready",  in_ready0,  1'b1);
    @(negedge clock);
    @(negedge clock);
    chk1("mid_rst_hold", out_valid0, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    chk1("after_rst_idle", out_valid0, 1'b0);
    run_one("after_rst", OP_DEQ, 32'h0000_2C00, 32'h0000_0000, 1'b0, 32'h0000_000B, 32'h0000_000B, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
